// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: execute-stage sequencer between decode and a clocked ALU.
// Accepts one op per handshake and drives the ALU operands, control and run.
// Captures the ALU result into a 2-entry writeback FIFO and keeps the NZCV register.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_op/in_a/in_b/in_dest/in_setf : op from decode
//   alu_din1/alu_din2/alu_control/alu_run              : registered ALU drive
//   alu_dout/alu_zf/alu_vf/alu_cf/alu_nf               : ALU result and flags
//   out_valid/out_ready/out_data/out_dest              : writeback FIFO head
//   flags_nzcv                                         : status register {N,Z,C,V}
module alu_issue_ctrl #(
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_setf,
    output logic [31:0]       alu_din1,
    output logic [31:0]       alu_din2,
    output logic [2:0]        alu_control,
    output logic              alu_run,
    input  logic [31:0]       alu_dout,
    input  logic              alu_zf,
    input  logic              alu_vf,
    input  logic              alu_cf,
    input  logic              alu_nf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic [3:0]        flags_nzcv
);
    typedef enum logic [1:0] {IDLE, EXEC, SHIFT_WAIT} state_t;

    state_t            r_state;
    logic              r_live;
    logic              r_run;
    logic [31:0]       r_din1;
    logic [31:0]       r_din2;
    logic [2:0]        r_ctrl;
    logic [DEST_W-1:0] r_dest;
    logic              r_setf;
    logic [3:0]        r_nzcv;
    logic [1:0]        r_count;
    logic [31:0]       r_data [2];
    logic [DEST_W-1:0] r_dst  [2];

    logic w_accept;
    logic w_cap;
    logic w_pop;
    logic w_widx;

    // r_live holds in_ready low until the first edge after reset release
    assign in_ready    = r_live && r_state == IDLE && r_count != 2'd2;
    assign w_accept    = in_valid && in_ready;
    assign w_cap       = (r_state == EXEC && !(r_ctrl[2] && r_ctrl[1])) || r_state == SHIFT_WAIT;
    assign w_pop       = out_valid && out_ready;
    // slot for the captured entry is count - pop, which only ever lands in 0 or 1
    assign w_widx      = r_count[0] ^ w_pop;
    assign out_valid   = r_count != 2'd0;
    assign out_data    = r_data[0];
    assign out_dest    = r_dst[0];
    assign alu_din1    = r_din1;
    assign alu_din2    = r_din2;
    assign alu_control = r_ctrl;
    assign alu_run     = r_run;
    assign flags_nzcv  = r_nzcv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_live   <= 1'b0;
            r_run    <= 1'b1;
            r_din1   <= '0;
            r_din2   <= '0;
            r_ctrl   <= '0;
            r_dest   <= '0;
            r_setf   <= 1'b0;
            r_nzcv   <= '0;
            r_count  <= '0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_dst[0]  <= '0;
            r_dst[1]  <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                IDLE: begin
                    // NOP is consumed here so the ALU never runs with control 000
                    if (w_accept && in_op != 3'b000) begin
                        r_din1  <= in_a;
                        r_din2  <= in_b;
                        r_ctrl  <= in_op;
                        r_dest  <= in_dest;
                        r_setf  <= in_setf;
                        r_run   <= 1'b0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (r_ctrl[2] && r_ctrl[1]) begin
                        r_state <= SHIFT_WAIT;
                    end else begin
                        r_state <= IDLE;
                        r_run   <= 1'b1;
                    end
                end
                SHIFT_WAIT: begin
                    r_state <= IDLE;
                    r_run   <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
            if (w_cap && r_setf)
                r_nzcv <= {alu_nf, alu_zf, alu_cf, alu_vf};
            if (w_pop) begin
                r_data[0] <= r_data[1];
                r_dst[0]  <= r_dst[1];
            end
            if (w_cap) begin
                r_data[w_widx] <= alu_dout;
                r_dst[w_widx]  <= r_dest;
            end
            r_count <= r_count + 2'(w_cap) - 2'(w_pop);
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a behavioural 16-bit ALU.
module tb_alu_issue_ctrl;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [2:0]  in_op = 0;
    logic [31:0] in_a = 0;
    logic [31:0] in_b = 0;
    logic [3:0]  in_dest = 0;
    logic        in_setf = 0;
    logic [31:0] alu_din1;
    logic [31:0] alu_din2;
    logic [2:0]  alu_control;
    logic        alu_run;
    logic [31:0] alu_dout;
    logic        alu_zf, alu_vf, alu_cf, alu_nf;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_data;
    logic [3:0]  out_dest;
    logic [3:0]  flags_nzcv;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEST_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest), .in_setf(in_setf),
        .alu_din1(alu_din1), .alu_din2(alu_din2), .alu_control(alu_control), .alu_run(alu_run),
        .alu_dout(alu_dout), .alu_zf(alu_zf), .alu_vf(alu_vf), .alu_cf(alu_cf), .alu_nf(alu_nf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
        .flags_nzcv(flags_nzcv)
    );

    // 16-bit ALU: result sign-extended, C is carry-out for ADD and no-borrow for SUB
    logic [15:0] a16, b16, r16;
    logic [16:0] s17;
    always_comb begin
        a16    = alu_din1[15:0];
        b16    = alu_din2[15:0];
        s17    = '0;
        alu_cf = 1'b0;
        alu_vf = 1'b0;
        case (alu_control)
            3'b001: begin
                s17    = {1'b0, a16} + {1'b0, b16};
                alu_cf = s17[16];
                alu_vf = (a16[15] == b16[15]) && (s17[15] != a16[15]);
            end
            3'b010: begin
                s17    = {1'b0, a16} - {1'b0, b16};
                alu_cf = !s17[16];
                alu_vf = (a16[15] != b16[15]) && (s17[15] != a16[15]);
            end
            3'b011:  s17 = {1'b0, a16 & b16};
            3'b100:  s17 = {1'b0, a16 | b16};
            3'b101:  s17 = {1'b0, a16 ^ b16};
            3'b110,
            3'b111:  s17 = {1'b0, a16 << b16[3:0]};
            default: s17 = '0;
        endcase
        r16      = s17[15:0];
        alu_dout = {{16{r16[15]}}, r16};
        alu_nf   = r16[15];
        alu_zf   = r16 == 16'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issues one non-NOP op and returns in the cycle after its capture edge
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] d, input logic s);
        check("rdy_before", in_ready, 1);
        in_valid = 1; in_op = op; in_a = a; in_b = b; in_dest = d; in_setf = s;
        tick();
        in_valid = 0; in_a = 32'hDEAD_BEEF; in_b = 32'hDEAD_BEEF; in_op = 3'b000;
        check("run_lo_exec", alu_run, 0);
        check("busy_exec", in_ready, 0);
        if (op[2] && op[1]) begin
            tick();
            check("run_lo_shift", alu_run, 0);
            check("ov_shift_wait", out_valid, 0);
        end
        tick();
        check("run_hi_cap", alu_run, 1);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_ov", out_valid, 0);
        check("rst_run", alu_run, 1);
        check("rst_flags", flags_nzcv, 4'h0);
        check("rst_rdy", in_ready, 0);
        check("rst_data", out_data, 0);
        check("rst_dest", out_dest, 0);
        check("rst_ctrl", alu_control, 0);
        check("rst_din1", alu_din1, 0);
        @(negedge clk);
        rst = 1;
        #1;
        check("rdy_pre_edge", in_ready, 0);
        tick();
        check("rdy_post_rst", in_ready, 1);

        // ADD with flags
        out_ready = 1;
        in_valid = 1; in_op = 3'b001; in_a = 32'h6075; in_b = 32'h5105; in_dest = 4'd3; in_setf = 1;
        tick();
        in_valid = 0;
        check("add_run", alu_run, 0);
        check("add_ctrl", alu_control, 3'b001);
        check("add_din1", alu_din1, 32'h6075);
        check("add_din2", alu_din2, 32'h5105);
        check("add_ov1", out_valid, 0);
        tick();
        check("add_ov2", out_valid, 1);
        check("add_data", out_data, 32'hFFFF_B17A);
        check("add_dest", out_dest, 3);
        check("add_flags", flags_nzcv, 4'h9);
        check("add_rdy2", in_ready, 1);

        // logic/sub sweep back to back, setf=0 keeps flags
        run_op(3'b010, 32'h1F75, 32'h108A, 4'd1, 0);
        check("sub_data", out_data, 32'h0000_0EEB);
        check("sub_dest", out_dest, 1);
        run_op(3'b011, 32'h1F75, 32'h108A, 4'd2, 0);
        check("and_data", out_data, 32'h0000_1000);
        check("and_dest", out_dest, 2);
        run_op(3'b100, 32'h1F75, 32'h108A, 4'd4, 0);
        check("or_data", out_data, 32'h0000_1FFF);
        check("or_dest", out_dest, 4);
        run_op(3'b101, 32'h1F75, 32'h108A, 4'd5, 0);
        check("xor_data", out_data, 32'h0000_0FFF);
        check("xor_dest", out_dest, 5);
        check("sweep_flags", flags_nzcv, 4'h9);

        // zero result, then flag hold
        run_op(3'b010, 32'h1234, 32'h1234, 4'd6, 1);
        check("z_data", out_data, 0);
        check("z_flags", flags_nzcv, 4'h6);
        run_op(3'b001, 32'h1, 32'h2, 4'd7, 0);
        check("hold_data", out_data, 3);
        check("hold_flags", flags_nzcv, 4'h6);

        // shift takes the extra cycle
        run_op(3'b110, 32'h3, 32'h4, 4'd8, 0);
        check("lsl_ov", out_valid, 1);
        check("lsl_data", out_data, 32'h30);
        check("lsl_dest", out_dest, 8);

        // NOP
        in_valid = 1; in_op = 3'b000; in_a = 32'h5; in_b = 32'h5; in_dest = 4'd9; in_setf = 1;
        tick();
        in_valid = 0;
        check("nop_run", alu_run, 1);
        check("nop_rdy", in_ready, 1);
        tick();
        check("nop_run2", alu_run, 1);
        check("nop_ov", out_valid, 0);
        check("nop_flags", flags_nzcv, 4'h6);

        // backpressure
        out_ready = 0;
        run_op(3'b001, 32'h1, 32'h1, 4'd1, 0);
        check("bp_cnt1_rdy", in_ready, 1);
        run_op(3'b001, 32'h2, 32'h2, 4'd2, 0);
        check("bp_full_rdy", in_ready, 0);
        check("bp_head", out_data, 2);
        in_valid = 1; in_op = 3'b001; in_a = 32'h3; in_b = 32'h3; in_dest = 4'd5; in_setf = 0;
        tick();
        check("bp_stall_run", alu_run, 1);
        check("bp_stall_rdy", in_ready, 0);
        out_ready = 1;
        tick();
        out_ready = 0;
        check("bp_pop_rdy", in_ready, 1);
        check("bp_head2", out_data, 4);
        check("bp_dest2", out_dest, 2);
        tick();
        in_valid = 0;
        check("bp_third_run", alu_run, 0);
        tick();
        check("bp_head_keep", out_data, 4);
        check("bp_full2", in_ready, 0);
        out_ready = 1;
        tick();
        check("bp_head3", out_data, 6);
        check("bp_dest3", out_dest, 5);
        tick();
        check("bp_empty", out_valid, 0);

        // reset during EXEC
        out_ready = 0;
        run_op(3'b001, 32'h5, 32'h5, 4'd7, 0);
        in_valid = 1; in_op = 3'b001; in_a = 32'h7FFF; in_b = 32'h1; in_dest = 4'd3; in_setf = 1;
        tick();
        in_valid = 0;
        check("mid_run", alu_run, 0);
        rst = 0;
        #1;
        check("mr_ov", out_valid, 0);
        check("mr_run", alu_run, 1);
        check("mr_flags", flags_nzcv, 4'h0);
        check("mr_rdy", in_ready, 0);
        repeat (2) tick();
        @(negedge clk);
        rst = 1;
        repeat (3) tick();
        check("mr_no_stale", out_valid, 0);
        check("mr_flags2", flags_nzcv, 4'h0);
        out_ready = 1;
        run_op(3'b010, 32'h1, 32'h2, 4'd4, 1);
        check("post_data", out_data, 32'hFFFF_FFFF);
        check("post_dest", out_dest, 4);
        check("post_flags", flags_nzcv, 4'h8);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
